// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with a flush input.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  output fetch_entry_t  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: PC generator, pipelined imem port, prefetch queue.
// Optional macro FETCH_BYPASS_EN lets a response reach if_* in its arrival cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault,
  input  logic            id_ready
);

  localparam int CW  = cnt_width(DEPTH);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            halted_q, halted_d;

  logic            req, gnt_acc, rsp_acc, push, pop;
  fetch_entry_t    rsp_entry, head, out_entry;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;

  // Every issued request must have a guaranteed queue slot for its response.
  assign req     = !reset && !redirect && !halted_q && !fifo_full &&
                   (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W);
  assign gnt_acc = req && imem_gnt;
  assign rsp_acc = imem_rvalid && !reset && !redirect && (discard_q == '0);

  assign rsp_entry = '{pc: rsp_pc_q, inst: imem_rdata, fault: imem_err};

`ifdef FETCH_BYPASS_EN
  logic bypass_take;
  assign bypass_take = rsp_acc && fifo_empty;
  assign if_valid    = (bypass_take || !fifo_empty) && !reset && !redirect;
  assign out_entry   = bypass_take ? rsp_entry : head;
  assign push        = rsp_acc && !(bypass_take && id_ready);
`else
  assign if_valid    = !fifo_empty && !reset && !redirect;
  assign out_entry   = head;
  assign push        = rsp_acc;
`endif

  assign pop       = !fifo_empty && if_valid && id_ready;
  assign if_inst   = if_valid ? out_entry.inst : NOP_INST;
  assign if_pc     = if_valid ? out_entry.pc : '0;
  assign if_fault  = if_valid && out_entry.fault;
  assign imem_req  = req;
  assign imem_addr = fetch_addr_q;

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    rsp_pc_d      = rsp_pc_q;
    halted_d      = halted_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(gnt_acc) - CW'(imem_rvalid);
    if (redirect) begin
      // Everything still in flight belongs to the abandoned stream.
      fetch_addr_d = redirect_pc & ~XLEN'(3);
      rsp_pc_d     = redirect_pc & ~XLEN'(3);
      halted_d     = 1'b0;
      discard_d    = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (gnt_acc) fetch_addr_d = fetch_addr_q + XLEN'(4);
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (rsp_acc) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        if (imem_err) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_q  <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (redirect),
    .push_i  (push),
    .wdata_i (rsp_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order, variable-latency imem model.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk, reset, redirect, imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_inst, if_pc;
  logic        if_valid, if_fault, id_ready;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_fault(if_fault),
    .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } mrsp_t;

  exp_t        sb[$];
  mrsp_t       memq[$];
  logic [31:0] pop_log[$];
  int          n_vec, n_err, cyc_n, pops, last_rdy, mem_lat;
  int          gnt_pct, rdy_pct, rsp_pct, gnt_cyc, pop300_cyc;
  logic [31:0] exp_fetch, err_addr, prev_addr, last_gnt_addr, fault_pc;
  bit          prev_stall, halt_exp, after_rst;

  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic tick(input bit rst = 1'b0, input bit redir = 1'b0,
                      input logic [31:0] rpc = 32'h0);
    exp_t e;
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    id_ready    = ($urandom_range(99) < rdy_pct);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_err    = 1'b0;
    if (memq.size() > 0 && memq[0].rdy <= cyc_n && $urandom_range(99) < rsp_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_inst(memq[0].addr);
      imem_err    = (memq[0].addr == err_addr);
      void'(memq.pop_front());
    end
    @(negedge clk);
    if (!rst && after_rst) begin
      chk("rst_ifv", {31'd0, if_valid}, 32'd0);
      chk("rst_inst", if_inst, 32'h13);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_fault", {31'd0, if_fault}, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      if (!redir) chk("rst_first_req", {31'd0, imem_req}, 32'd1);
      after_rst = 1'b0;
    end
    if (rst) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      sb.delete();
      memq.delete();
      exp_fetch  = RESET_PC;
      halt_exp   = 1'b0;
      prev_stall = 1'b0;
      last_rdy   = 0;
      after_rst  = 1'b1;
    end else if (redir) begin
      chk("redir_ifv", {31'd0, if_valid}, 32'd0);
      chk("redir_req", {31'd0, imem_req}, 32'd0);
      sb.delete();
      exp_fetch  = rpc & ~32'h3;
      halt_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !halt_exp) begin
        chk("hold_req", {31'd0, imem_req}, 32'd1);
        chk("hold_addr", imem_addr, prev_addr);
      end
      if (halt_exp) chk("halt_req", {31'd0, imem_req}, 32'd0);
      if (sb.size() >= DEPTH) chk("full_req", {31'd0, imem_req}, 32'd0);
      if (!if_valid) chk("nop_inst", if_inst, 32'h13);
      if (if_valid && id_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", if_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_inst", if_inst, e.inst);
          chk("if_fault", {31'd0, if_fault}, {31'd0, e.fault});
          pops++;
          pop_log.push_back(if_pc);
          if (if_fault) fault_pc = if_pc;
          if (if_pc == 32'h300) pop300_cyc = cyc_n;
        end
      end
      if (imem_req && imem_gnt) begin
        chk("imem_addr", imem_addr, exp_fetch);
        sb.push_back('{pc: exp_fetch, inst: mem_inst(exp_fetch), fault: (exp_fetch == err_addr)});
        last_rdy = (cyc_n + mem_lat > last_rdy) ? cyc_n + mem_lat : last_rdy;
        memq.push_back('{addr: imem_addr, rdy: last_rdy});
        exp_fetch     = exp_fetch + 32'd4;
        gnt_cyc       = cyc_n;
        last_gnt_addr = imem_addr;
      end
      prev_stall = imem_req && !imem_gnt;
      prev_addr  = imem_addr;
      if (imem_rvalid && imem_err) halt_exp = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int mark, p0;
    n_vec = 0; n_err = 0; cyc_n = 0; pops = 0; last_rdy = 0;
    gnt_pct = 100; rdy_pct = 100; rsp_pct = 100; mem_lat = 1;
    err_addr = 32'hFFFF_FF00; fault_pc = 32'h0; pop300_cyc = -1; gnt_cyc = 0;
    prev_stall = 0; halt_exp = 0; after_rst = 0; exp_fetch = RESET_PC;
    last_gnt_addr = 32'h0; prev_addr = 32'h0;
    reset = 1; redirect = 0; redirect_pc = 0; imem_gnt = 0; id_ready = 0;
    imem_rvalid = 0; imem_rdata = 0; imem_err = 0;

    // Streaming with full-rate grants and responses
    for (int i = 0; i < 3; i++) tick(1'b1);
    run(10);
    p0 = pops;
    run(20);
    chk("throughput", pops - p0, 20);

    // Back-pressure from ID fills the queue and stops issue
    rdy_pct = 0;
    run(10);
    chk("stall_fill", sb.size(), DEPTH);
    rdy_pct = 100;
    run(10);

    // Redirect with three requests in flight
    gnt_pct = 0;
    run(10);
    mem_lat = 6;
    gnt_pct = 100;
    run(3);
    chk("inflight3", memq.size(), 3);
    mark = pop_log.size();
    tick(1'b0, 1'b1, 32'h100);
    mem_lat = 1;
    run(20);
    chk("redir_first", (pop_log.size() > mark) ? pop_log[mark] : 32'hDEAD_BEEF, 32'h100);

    // Access fault halts fetch until the next redirect
    gnt_pct = 0;
    run(10);
    gnt_pct = 100;
    err_addr = 32'h8;
    tick(1'b0, 1'b1, 32'h0);
    run(20);
    chk("fault_pc", fault_pc, 32'h8);
    chk("fault_halted", {31'd0, imem_req}, 32'd0);
    err_addr = 32'hFFFF_FF00;
    mark = pop_log.size();
    tick(1'b0, 1'b1, 32'h40);
    run(20);
    chk("resume", (pop_log.size() > mark) ? pop_log[mark] : 32'hDEAD_BEEF, 32'h40);

    // Misaligned redirect target, then reset with responses pending
    tick(1'b0, 1'b1, 32'h203);
    chk("align", imem_addr, 32'h200);
    mem_lat = 3;
    run(5);
    chk("pending_before_rst", {31'd0, memq.size() > 0}, 32'd1);
    tick(1'b1);
    mem_lat = 1;
    run(20);

    // First-fetch latency from an empty queue
    gnt_pct = 0;
    run(10);
    tick(1'b0, 1'b1, 32'h300);
    run(3);
    gnt_pct = 100;
    pop300_cyc = -1;
    tick();
    gnt_pct = 0;
    chk("lat_gnt_addr", last_gnt_addr, 32'h300);
    run(10);
    chk("latency", pop300_cyc - gnt_cyc, EXP_LAT);

    // Random grants, stalls, latencies and redirects
    gnt_pct = 70; rdy_pct = 70; rsp_pct = 70;
    for (int i = 0; i < 600; i++) begin
      mem_lat = $urandom_range(1, 3);
      tick(1'b0, ($urandom_range(39) == 0), $urandom_range(0, 4095));
    end
    gnt_pct = 0; rdy_pct = 100; rsp_pct = 100;
    run(20);
    chk("drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
